dma_prog_master: RTL and testbench
==================================

DMA_PROG_MASTER -- requirements
Module: dma_prog_master

Interface
REQ-001 SHALL have parameter STB_CYCLES, default 2, meaning number of cycles IOW_N/IOR_N is held low per bus cycle (legal 1..15).
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to program a channel; sampled only in IDLE.
REQ-005 SHALL have port ch  input  2  target channel, captured with start.
REQ-006 SHALL have port base_addr  input  16  base address, captured with start.
REQ-007 SHALL have port word_count  input  16  base word count, captured with start.
REQ-008 SHALL have port mode  input  6  mode byte bits [7:2] (mode_sel, addr_inc_dec, auto_init_en, trans_type), captured with start.
REQ-009 SHALL have ports busy (output, 1, operation in progress) and done (output, 1, one-cycle completion pulse).
REQ-010 SHALL have ports CS_N, IOW_N, IOR_N (output, 1 each, active-low chip select/write/read strobes), A (output, 4, register address), DB_OUT (output, 8, write data), DB_OE (output, 1, drive enable for DB_OUT), DB_IN (input, 8, read data).

Function
REQ-011 SHALL, on start in IDLE, capture inputs, assert busy next cycle, and issue 8 register writes in order: single mask set (A=4'ha, data {5'b0,1,ch}), mode (A=4'hb, {mode,ch}), clear byte flip-flop (A=4'hc, 8'h00), address low then high (A=2*ch), count low then high (A=2*ch+1), single mask clear (A=4'ha, {5'b0,0,ch}).
REQ-012 SHALL run each bus cycle through states SETUP (1 cycle: CS_N=0, A/DB_OUT valid, DB_OE=1 for writes, strobes high), STROBE (STB_CYCLES cycles: strobe low), HOLD (1 cycle: strobe high, CS_N=0, A/data held), GAP (1 cycle: CS_N=1, DB_OE=0).
REQ-013 SHALL hold A and DB_OUT stable from SETUP through HOLD; never assert IOW_N and IOR_N together; never assert a strobe with CS_N high.
REQ-014 SHALL use a 3-bit step counter 0..7 advanced in GAP; after step 7 GAP, go to DONE (1 cycle: done=1, busy=0 same cycle), then IDLE.
REQ-015 SHALL, with STB_CYCLES=2 and no polling, pulse done exactly 41 cycles after the start cycle (8 x 5 cycles + 1).
REQ-016 SHALL ignore start while busy or in DONE; captured values SHALL not change mid-operation.
REQ-017 SHALL write the count register with word_count as given (no minus-one adjustment; caller supplies 8237 N-1 convention).

Reset
REQ-018 SHALL, on RESET assertion (including mid-bus-cycle), immediately force CS_N=1, IOW_N=1, IOR_N=1, DB_OE=0, A=0, DB_OUT=0, busy=0, done=0, step=0, state IDLE.
REQ-019 SHALL accept a start on the first clock edge after RESET deassertion.

Configuration
REQ-020 SHALL, when DMA_STATUS_POLL_EN is defined, after step 7 enter POLL: repeat read cycles (A=4'h8, IOR_N strobe, DB_OE=0), sampling DB_IN on the last STROBE cycle, until DB_IN[ch] (terminal-count bit) is 1, then DONE.
REQ-021 SHALL, when DMA_STATUS_POLL_EN is undefined, contain no read logic: IOR_N tied 1, DB_IN unused, DONE follows step 7 directly.

Structure
REQ-022 SHALL place the register address constants and mode/mask byte layouts in the shared DMA register package, plus a new enum for the master state (IDLE, SETUP, STROBE, HOLD, GAP, POLL, DONE).
REQ-023 SHALL implement bus timing in one sub-module dma_io_cycle (request, rd/wr, addr, data in; strobes and ack out); the sequencer sits in dma_prog_master.

Verification
REQ-024 SHALL cover: RESET, start ch=2, base_addr=16'h1234, word_count=16'h00FF, mode=6'b010001 -> writes (A,data) = (a,06),(b,46),(c,00),(4,34),(4,12),(5,FF),(5,00),(a,02); done at cycle 41.
REQ-025 SHALL cover: start pulsed again at cycle 10 with ch=0 -> ignored; write sequence identical to prior scenario.
REQ-026 SHALL cover: RESET asserted during STROBE of step 3 -> IOW_N, CS_N high same cycle, busy=0; next start ch=1 completes full 8-write sequence from step 0.
REQ-027 SHALL cover: STB_CYCLES=1, ch=3 -> IOW_N low exactly 1 cycle per write, done 33 cycles after start.
REQ-028 SHALL cover: DMA_STATUS_POLL_EN defined, ch=1, DB_IN=8'h00 for 3 reads then 8'h02 -> exactly 4 reads at A=4'h8, done one cycle after 4th read GAP.

Source files
------------

// File: rtl/dma_prog_master_pkg.sv
// dma_prog_master_pkg -- shared 8237 DMA register definitions.
//
// Holds the 8237 register addresses, the mode/mask byte layouts and the
// state enum used by the programming master and its bus-cycle engine.
// Optional feature macro used by the consumers: DMA_STATUS_POLL_EN.
package dma_prog_master_pkg;

  // 8237 register map (low nibble of the I/O address)
  localparam logic [3:0] REG_STATUS   = 4'h8;  // read: status (TC bits in [3:0])
  localparam logic [3:0] REG_SMASK    = 4'ha;  // write: single mask bit
  localparam logic [3:0] REG_MODE     = 4'hb;  // write: mode register
  localparam logic [3:0] REG_CLR_FF   = 4'hc;  // write: clear byte pointer flip-flop

  // Mode byte bits [7:2]; bits [1:0] carry the channel number.
  typedef struct packed {
    logic [1:0] mode_sel;
    logic       addr_dec;
    logic       auto_init;
    logic [1:0] trans_type;
  } mode_bits_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP,
    ST_POLL,
    ST_DONE
  } dma_state_e;

  // Single mask byte: bit 2 = set/clear, bits [1:0] = channel.
  function automatic logic [7:0] mask_byte(input logic set, input logic [1:0] ch);
    return {5'b00000, set, ch};
  endfunction

  function automatic logic [7:0] mode_byte(input mode_bits_t m, input logic [1:0] ch);
    return {m, ch};
  endfunction

  // Per-channel base address / word count register addresses.
  function automatic logic [3:0] addr_reg(input logic [1:0] ch);
    return {1'b0, ch, 1'b0};
  endfunction

  function automatic logic [3:0] count_reg(input logic [1:0] ch);
    return {1'b0, ch, 1'b1};
  endfunction

endpackage

// File: rtl/dma_io_cycle.sv
// dma_io_cycle -- one 8237 register access on the host I/O bus.
//
// Runs SETUP (1) -> STROBE (STB_CYCLES) -> HOLD (1) -> GAP (1). A new
// request presented during GAP starts the next access without an idle
// cycle. addr/wdata/rd must stay stable while the access is active; the
// caller keeps them registered. Read data is captured on the last STROBE
// cycle. Read support only exists when DMA_STATUS_POLL_EN is defined.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             start an access (taken in IDLE or GAP)
//   rd              1 = read access, 0 = write access
//   addr, wdata     register address / write data
//   db_in           bus read data
//   cs_n, iow_n,
//   ior_n           active-low chip select and strobes
//   a, db_out,
//   db_oe           bus address, write data and its drive enable
//   ack             high during GAP (access complete)
//   rdata           data captured by the most recent read
import dma_prog_master_pkg::*;

module dma_io_cycle #(
  parameter int STB_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rd,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] db_in,
  output logic       cs_n,
  output logic       iow_n,
  output logic       ior_n,
  output logic [3:0] a,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       ack,
  output logic [7:0] rdata
);

  localparam logic [3:0] STB_LAST = 4'(STB_CYCLES - 1);

  dma_state_e phase, phase_next;
  logic [3:0] cnt, cnt_next;
  logic       active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    unique case (phase)
      ST_IDLE:   if (req) phase_next = ST_SETUP;
      ST_SETUP: begin
        phase_next = ST_STROBE;
        cnt_next   = 4'd0;
      end
      ST_STROBE: begin
        if (cnt == STB_LAST) phase_next = ST_HOLD;
        else                 cnt_next   = cnt + 4'd1;
      end
      ST_HOLD:   phase_next = ST_GAP;
      ST_GAP:    phase_next = req ? ST_SETUP : ST_IDLE;
      default:   phase_next = ST_IDLE;
    endcase
  end

  // Address/data are gated to zero outside the access so reset clears the
  // bus immediately without waiting for a clock.
  assign active = (phase == ST_SETUP) || (phase == ST_STROBE) || (phase == ST_HOLD);
  assign cs_n   = !active;
  assign iow_n  = !((phase == ST_STROBE) && !rd);
  assign a      = active ? addr : 4'h0;
  assign db_oe  = active && !rd;
  assign db_out = (active && !rd) ? wdata : 8'h00;
  assign ack    = (phase == ST_GAP);

`ifdef DMA_STATUS_POLL_EN
  assign ior_n = !((phase == ST_STROBE) && rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             rdata <= 8'h00;
    else if (phase == ST_STROBE && cnt == STB_LAST && rd) rdata <= db_in;
  end
`else
  logic unused_rd_path;
  assign ior_n          = 1'b1;
  assign rdata          = 8'h00;
  assign unused_rd_path = ^db_in;
`endif

endmodule

// File: rtl/dma_prog_master.sv
// dma_prog_master -- programs one 8237 DMA channel over the host I/O bus.
//
// On start (IDLE only) it captures ch/base_addr/word_count/mode and issues
// eight register writes: mask set, mode, clear flip-flop, address lo/hi,
// count lo/hi, mask clear. word_count is written unchanged (caller applies
// the 8237 N-1 convention). With DMA_STATUS_POLL_EN defined it then reads
// the status register until the channel's terminal-count bit is set.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   start               one-cycle program request
//   ch, base_addr,
//   word_count, mode    programming values, captured with start
//   busy                operation in progress
//   done                one-cycle completion pulse
//   CS_N, IOW_N, IOR_N  active-low chip select and strobes
//   A, DB_OUT, DB_OE    register address, write data, data drive enable
//   DB_IN               read data
import dma_prog_master_pkg::*;

module dma_prog_master #(
  parameter int STB_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [1:0]  ch,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  input  logic [5:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        CS_N,
  output logic        IOW_N,
  output logic        IOR_N,
  output logic [3:0]  A,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  input  logic [7:0]  DB_IN
);

  dma_state_e  state, state_next;
  logic [2:0]  step, step_next;
  logic [1:0]  ch_q;
  logic [15:0] base_q;
  logic [15:0] count_q;
  mode_bits_t  mode_q;
  logic        req;
  logic        rd;
  logic        ack;
  logic [3:0]  req_addr;
  logic [7:0]  req_data;
  logic [7:0]  rdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      step  <= 3'd0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  // Programming values only change on an accepted start.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && start) begin
      ch_q    <= ch;
      base_q  <= base_addr;
      count_q <= word_count;
      mode_q  <= mode_bits_t'(mode);
    end
  end

  // The sequencer stays in ST_SETUP for the whole write program; the
  // per-access SETUP/STROBE/HOLD/GAP phases live in dma_io_cycle.
  // Follow-on requests are raised during GAP so accesses run back to back.
  always_comb begin
    state_next = state;
    step_next  = step;
    req        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
          step_next  = 3'd0;
          req        = 1'b1;
        end
      end
      ST_SETUP: begin
        busy = 1'b1;
        if (ack) begin
          step_next = step + 3'd1;
          if (step == 3'd7) begin
`ifdef DMA_STATUS_POLL_EN
            state_next = ST_POLL;
            req        = 1'b1;
`else
            state_next = ST_DONE;
`endif
          end else begin
            req = 1'b1;
          end
        end
      end
`ifdef DMA_STATUS_POLL_EN
      ST_POLL: begin
        busy = 1'b1;
        if (ack) begin
          if (rdata[ch_q]) state_next = ST_DONE;
          else             req        = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_addr = REG_SMASK;
    req_data = 8'h00;
    if (state == ST_POLL) begin
      req_addr = REG_STATUS;
    end else begin
      unique case (step)
        3'd0: begin req_addr = REG_SMASK;       req_data = mask_byte(1'b1, ch_q);    end
        3'd1: begin req_addr = REG_MODE;        req_data = mode_byte(mode_q, ch_q);  end
        3'd2: begin req_addr = REG_CLR_FF;      req_data = 8'h00;                    end
        3'd3: begin req_addr = addr_reg(ch_q);  req_data = base_q[7:0];              end
        3'd4: begin req_addr = addr_reg(ch_q);  req_data = base_q[15:8];             end
        3'd5: begin req_addr = count_reg(ch_q); req_data = count_q[7:0];             end
        3'd6: begin req_addr = count_reg(ch_q); req_data = count_q[15:8];            end
        default: begin req_addr = REG_SMASK;    req_data = mask_byte(1'b0, ch_q);    end
      endcase
    end
  end

`ifdef DMA_STATUS_POLL_EN
  assign rd = (state == ST_POLL);
`else
  logic unused_rdata;
  assign rd           = 1'b0;
  assign unused_rdata = ^rdata;
`endif

  dma_io_cycle #(
    .STB_CYCLES(STB_CYCLES)
  ) u_io (
    .clk    (CLK),
    .rst    (RESET),
    .req    (req),
    .rd     (rd),
    .addr   (req_addr),
    .wdata  (req_data),
    .db_in  (DB_IN),
    .cs_n   (CS_N),
    .iow_n  (IOW_N),
    .ior_n  (IOR_N),
    .a      (A),
    .db_out (DB_OUT),
    .db_oe  (DB_OE),
    .ack    (ack),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_dma_prog_master.sv
// tb_dma_prog_master -- self-checking bench for dma_prog_master.
// u_dut0 runs with STB_CYCLES=2, u_dut1 with STB_CYCLES=1. Expected bus
// writes are queued when an operation is started and popped by per-DUT
// monitors on each IOW_N falling edge. Honours DMA_STATUS_POLL_EN.
`timescale 1ns/1ps
module tb_dma_prog_master;

`ifdef DMA_STATUS_POLL_EN
  localparam int NPOLL = 1;
`else
  localparam int NPOLL = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [1:0]  ch_i = 2'd0;
  logic [15:0] base_i = 16'h0, wc_i = 16'h0;
  logic [5:0]  mode_i = 6'h0;
  logic        busy0, done0, cs_n0, iow_n0, ior_n0, dboe0;
  logic        busy1, done1, cs_n1, iow_n1, ior_n1, dboe1;
  logic [3:0]  a0, a1;
  logic [7:0]  dbo0, dbo1;
  logic [7:0]  dbi0;
  logic [7:0]  dbi1 = 8'hff;

  int checks = 0, errors = 0, cyc = 0;
  int wr0 = 0, rd0 = 0, rd_base = 0;
  logic poll_mode = 1'b0;
  logic [11:0] exp0[$], exp1[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  assign dbi0 = poll_mode ? (((rd0 - rd_base) >= 4) ? 8'h02 : 8'h00) : 8'hff;

  dma_prog_master #(.STB_CYCLES(2)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .start(start0), .ch(ch_i), .base_addr(base_i),
    .word_count(wc_i), .mode(mode_i), .busy(busy0), .done(done0), .CS_N(cs_n0),
    .IOW_N(iow_n0), .IOR_N(ior_n0), .A(a0), .DB_OUT(dbo0), .DB_OE(dboe0), .DB_IN(dbi0));

  dma_prog_master #(.STB_CYCLES(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .start(start1), .ch(ch_i), .base_addr(base_i),
    .word_count(wc_i), .mode(mode_i), .busy(busy1), .done(done1), .CS_N(cs_n1),
    .IOW_N(iow_n1), .IOR_N(ior_n1), .A(a1), .DB_OUT(dbo1), .DB_OE(dboe1), .DB_IN(dbi1));

  // Monitor for u_dut0
  logic iow_p0 = 1'b1, ior_p0 = 1'b1;
  int low0 = 0;
  logic [3:0] acap0;
  logic [7:0] dcap0;
  logic [11:0] e0;
  always @(negedge CLK) begin
    if (iow_n0 === 1'b0) begin
      checks++;
      if (cs_n0 !== 1'b0 || ior_n0 !== 1'b1) begin
        errors++; $display("FAIL dut0_strobe_qualify: cs_n=%b ior_n=%b, required cs_n=0 ior_n=1", cs_n0, ior_n0);
      end
      if (iow_p0 === 1'b1) begin
        wr0++; low0 = 1; acap0 = a0; dcap0 = dbo0; checks++;
        if (exp0.size() == 0) begin
          errors++; $display("FAIL dut0_unexpected_write: got A=%h D=%h, required no write", a0, dbo0);
        end else begin
          e0 = exp0.pop_front();
          if ({a0, dbo0} !== e0) begin
            errors++; $display("FAIL dut0_write: got A=%h D=%h, required A=%h D=%h", a0, dbo0, e0[11:8], e0[7:0]);
          end
        end
      end else low0++;
    end else if (iow_p0 === 1'b0 && RESET === 1'b0) begin
      checks++;
      if (low0 !== 2) begin errors++; $display("FAIL dut0_strobe_len: got %0d, required 2", low0); end
      checks++;
      if ({a0, dbo0, cs_n0, dboe0} !== {acap0, dcap0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL dut0_hold: got A=%h D=%h cs_n=%b oe=%b, required A=%h D=%h cs_n=0 oe=1",
                           a0, dbo0, cs_n0, dboe0, acap0, dcap0);
      end
    end
    if (ior_n0 === 1'b0 && ior_p0 === 1'b1) begin
      rd0++; checks++;
      if ({a0, cs_n0, dboe0, iow_n0} !== {4'h8, 1'b0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL dut0_read_cycle: got A=%h cs_n=%b oe=%b iow_n=%b, required A=8 cs_n=0 oe=0 iow_n=1",
                           a0, cs_n0, dboe0, iow_n0);
      end
    end
    iow_p0 = iow_n0;
    ior_p0 = ior_n0;
  end

  // Monitor for u_dut1
  logic iow_p1 = 1'b1;
  int low1 = 0;
  logic [11:0] e1;
  always @(negedge CLK) begin
    if (iow_n1 === 1'b0) begin
      if (iow_p1 === 1'b1) begin
        low1 = 1; checks++;
        if (exp1.size() == 0) begin
          errors++; $display("FAIL dut1_unexpected_write: got A=%h D=%h, required no write", a1, dbo1);
        end else begin
          e1 = exp1.pop_front();
          if ({a1, dbo1, cs_n1} !== {e1, 1'b0}) begin
            errors++; $display("FAIL dut1_write: got A=%h D=%h cs_n=%b, required A=%h D=%h cs_n=0", a1, dbo1, cs_n1, e1[11:8], e1[7:0]);
          end
        end
      end else low1++;
    end else if (iow_p1 === 1'b0 && RESET === 1'b0) begin
      checks++;
      if (low1 !== 1) begin errors++; $display("FAIL dut1_strobe_len: got %0d, required 1", low1); end
    end
    iow_p1 = iow_n1;
  end

  task automatic push_gen(input int u, input logic [1:0] c, input logic [15:0] ba,
                          input logic [15:0] wc, input logic [5:0] m, input int n);
    logic [11:0] w[8];
    w[0] = {4'ha, 5'b00000, 1'b1, c};
    w[1] = {4'hb, m, c};
    w[2] = {4'hc, 8'h00};
    w[3] = {1'b0, c, 1'b0, ba[7:0]};
    w[4] = {1'b0, c, 1'b0, ba[15:8]};
    w[5] = {1'b0, c, 1'b1, wc[7:0]};
    w[6] = {1'b0, c, 1'b1, wc[15:8]};
    w[7] = {4'ha, 5'b00000, 1'b0, c};
    for (int i = 0; i < n; i++) begin
      if (u == 0) exp0.push_back(w[i]);
      else        exp1.push_back(w[i]);
    end
  endtask

  task automatic push_ref_seq();
    exp0.push_back(12'ha06); exp0.push_back(12'hb46); exp0.push_back(12'hc00); exp0.push_back(12'h434);
    exp0.push_back(12'h412); exp0.push_back(12'h5ff); exp0.push_back(12'h500); exp0.push_back(12'ha02);
  endtask

  // Starts one operation on DUT u (releasing RESET on the same edge) and
  // checks busy, done latency, single-cycle done and the write queue.
  task automatic go(input int u, input logic [1:0] c, input logic [15:0] ba, input logic [15:0] wc,
                    input logic [5:0] m, input int glitch_at, input int exp_lat, input string name);
    int t0, lat;
    logic d, b;
    @(negedge CLK);
    RESET = 1'b0;
    ch_i = c; base_i = ba; wc_i = wc; mode_i = m;
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    start0 = 1'b0; start1 = 1'b0;
    b = (u == 0) ? busy0 : busy1;
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL %s_busy_next: got %b, required 1", name, b); end
    lat = -1;
    for (int k = 1; k < 400; k++) begin
      d = (u == 0) ? done0 : done1;
      if (d === 1'b1) begin
        lat = cyc - t0;
        b = (u == 0) ? busy0 : busy1;
        checks++;
        if (b !== 1'b0) begin errors++; $display("FAIL %s_busy_in_done: got %b, required 0", name, b); end
        break;
      end
      if (k == glitch_at && u == 0) begin
        start0 = 1'b1; ch_i = 2'd0; base_i = 16'hdead; wc_i = 16'hbeef; mode_i = 6'h3f;
      end else start0 = 1'b0;
      @(negedge CLK);
    end
    start0 = 1'b0;
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s_done_latency: got %0d, required %0d", name, lat, exp_lat); end
    @(negedge CLK);
    d = (u == 0) ? done0 : done1;
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b, required 0", name, d); end
    checks++;
    if (((u == 0) ? exp0.size() : exp1.size()) != 0) begin
      errors++; $display("FAIL %s_writes_left: got %0d, required 0", name, (u == 0) ? exp0.size() : exp1.size());
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({cs_n0, iow_n0, ior_n0, dboe0, a0, dbo0, busy0, done0} !== {4'b1110, 4'h0, 8'h00, 2'b00}) begin
      errors++; $display("FAIL reset_dut0: got cs=%b iow=%b ior=%b oe=%b A=%h D=%h busy=%b done=%b, required 1 1 1 0 0 00 0 0",
                         cs_n0, iow_n0, ior_n0, dboe0, a0, dbo0, busy0, done0);
    end
    checks++;
    if ({cs_n1, iow_n1, busy1, done1} !== 4'b1100) begin
      errors++; $display("FAIL reset_dut1: got cs=%b iow=%b busy=%b done=%b, required 1 1 0 0", cs_n1, iow_n1, busy1, done1);
    end
  endtask

  task automatic test_basic();
    int rb;
    rb = rd0;
    push_ref_seq();
    go(0, 2'd2, 16'h1234, 16'h00ff, 6'b010001, -1, 41 + 5 * NPOLL, "basic");
    checks++;
    if (rd0 - rb !== NPOLL) begin errors++; $display("FAIL basic_reads: got %0d, required %0d", rd0 - rb, NPOLL); end
  endtask

  task automatic test_ignore_start();
    push_ref_seq();
    go(0, 2'd2, 16'h1234, 16'h00ff, 6'b010001, 10, 41 + 5 * NPOLL, "ignore");
  endtask

  task automatic test_reset_mid();
    int base;
    logic found;
    base = wr0;
    push_gen(0, 2'd2, 16'ha5c3, 16'h0010, 6'b100110, 4);
    @(negedge CLK);
    ch_i = 2'd2; base_i = 16'ha5c3; wc_i = 16'h0010; mode_i = 6'b100110; start0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (wr0 == base + 4 && iow_n0 === 1'b0) begin found = 1'b1; break; end
      @(negedge CLK);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_reach_step3: got no strobe, required step 3 strobe"); end
    RESET = 1'b1;
    #1;
    checks++;
    if ({iow_n0, cs_n0, busy0, dboe0, a0, dbo0, done0} !== {4'b1100, 4'h0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL rmid_async: got iow=%b cs=%b busy=%b oe=%b A=%h D=%h done=%b, required 1 1 0 0 0 00 0",
                         iow_n0, cs_n0, busy0, dboe0, a0, dbo0, done0);
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp0.size() != 0) begin errors++; $display("FAIL rmid_writes_before_abort: got %0d left, required 0", exp0.size()); end
    push_gen(0, 2'd1, 16'h4321, 16'h0200, 6'b000100, 8);
    go(0, 2'd1, 16'h4321, 16'h0200, 6'b000100, -1, 41 + 5 * NPOLL, "restart");
  endtask

  task automatic test_stb1();
    push_gen(1, 2'd3, 16'hc0de, 16'h7f80, 6'b111010, 8);
    go(1, 2'd3, 16'hc0de, 16'h7f80, 6'b111010, -1, 33 + 4 * NPOLL, "stb1");
  endtask

`ifdef DMA_STATUS_POLL_EN
  task automatic test_poll();
    rd_base = rd0;
    poll_mode = 1'b1;
    push_gen(0, 2'd1, 16'h0a0b, 16'h0003, 6'b010100, 8);
    go(0, 2'd1, 16'h0a0b, 16'h0003, 6'b010100, -1, 61, "poll");
    checks++;
    if (rd0 - rd_base !== 4) begin errors++; $display("FAIL poll_reads: got %0d, required 4", rd0 - rd_base); end
    poll_mode = 1'b0;
  endtask
`endif

  initial begin
    #1 RESET = 1'b1;
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_stb1();
`ifdef DMA_STATUS_POLL_EN
    test_poll();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
